// File: rtl/cla_bcd_seg_adder_if.sv
// Request/result bundle for cla_bcd_seg_adder: operands and start in,
// registered sum, conversion status, BCD digits and segment codes out.
interface cla_bcd_seg_adder_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic                  cin;
    logic [WIDTH-1:0]      sum;
    logic                  cout;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [8*DIGITS-1:0]   seg;

    modport master (
        output start, a, b, cin,
        input  sum, cout, busy, done, bcd, seg
    );

    modport slave (
        input  start, a, b, cin,
        output sum, cout, busy, done, bcd, seg
    );
endinterface

// File: rtl/cla_bcd_seg_adder.sv
// Registered nibble-group carry-lookahead adder feeding a sequential
// double-dabble BCD converter and an active-low 7-segment decoder.
module cla_bcd_seg_adder #(
    parameter int WIDTH  = 8,   // multiple of 4, >= 4
    parameter int DIGITS = 3    // 10**DIGITS must exceed 2**(WIDTH+1)-1
) (
    input  logic                clk,
    input  logic                rst,
    cla_bcd_seg_adder_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]       LAST      = CW'(WIDTH);
    localparam logic [8*DIGITS-1:0] SEG_RESET = {{(DIGITS-1){8'hff}}, 8'h03};

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t               state_q, state_d;
    logic                 accept, load_out;
    logic [WIDTH-1:0]     sum_c, sum_q;
    logic                 cout_c, cout_q;
    logic [WIDTH:0]       shreg_q;
    logic [4*DIGITS-1:0]  acc_q, acc_adj, bcd_q;
    logic [8*DIGITS-1:0]  seg_c, seg_q;
    logic [CW-1:0]        cnt_q;
    logic                 done_q;
    logic                 lead;
    logic                 c;
    logic [3:0]           g, p;
    logic [4:0]           cv;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 8'h03;
            4'd1:    seg_of = 8'h9f;
            4'd2:    seg_of = 8'h25;
            4'd3:    seg_of = 8'h0d;
            4'd4:    seg_of = 8'h99;
            4'd5:    seg_of = 8'h49;
            4'd6:    seg_of = 8'h41;
            4'd7:    seg_of = 8'h1f;
            4'd8:    seg_of = 8'h01;
            4'd9:    seg_of = 8'h09;
            default: seg_of = 8'hff;
        endcase
    endfunction

    // Lookahead inside each nibble; the group carry ripples to the next nibble.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        sum_c = '0;
        c     = bus.cin;
        g     = '0;
        p     = '0;
        cv    = '0;
        for (int n = 0; n < NIB; n++) begin
            g     = bus.a[4*n +: 4] & bus.b[4*n +: 4];
            p     = bus.a[4*n +: 4] ^ bus.b[4*n +: 4];
            cv[0] = c;
            cv[1] = g[0] | (p[0] & c);
            cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
            cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
            cv[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c);
            sum_c[4*n +: 4] = p ^ cv[3:0];
            c = cv[4];
        end
        cout_c = c;
    end

    always_comb begin
        acc_adj = acc_q;
        for (int d = 0; d < DIGITS; d++)
            if (acc_q[4*d +: 4] >= 4'd5)
                acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end

    // Digits above the most significant non-zero digit are blanked; digit 0 never is.
    always_comb begin
        seg_c = '0;
        lead  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (acc_q[4*i +: 4] != 4'd0)
                lead = 1'b0;
            seg_c[8*i +: 8] = (lead && i != 0) ? 8'hff : seg_of(acc_q[4*i +: 4]);
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        load_out = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                accept  = 1'b1;
                state_d = CONV;
            end
            CONV: if (cnt_q == LAST) state_d = DONE;
            DONE: begin
                load_out = 1'b1;
                accept   = bus.start;
                state_d  = bus.start ? CONV : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // On a DONE edge with start, acc is cleared while bcd/seg take its old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            seg_q   <= SEG_RESET;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            done_q <= load_out;
            if (accept) begin
                sum_q   <= sum_c;
                cout_q  <= cout_c;
                shreg_q <= {cout_c, sum_c};
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (state_q == CONV) begin
                acc_q   <= {acc_adj[4*DIGITS-2:0], shreg_q[WIDTH]};
                shreg_q <= {shreg_q[WIDTH-1:0], 1'b0};
                cnt_q   <= cnt_q + CW'(1);
            end
            if (load_out) begin
                bcd_q <= acc_q;
                seg_q <= seg_c;
            end
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = (state_q == CONV);
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
    assign bus.seg  = seg_q;
endmodule

// File: doc/cla_bcd_seg_adder.md
Name:
cla_bcd_seg_adder

Overview:
- Parametrised successor to the team's 4-bit carry-lookahead adder with 7-segment decode.
- Adds two WIDTH-bit operands plus carry-in using a registered, 4-bit-group carry-lookahead adder.
- Converts the (WIDTH+1)-bit result to BCD with a sequential shift-add-3 (double-dabble) engine, then drives one active-low 7-segment code per decimal digit.
- Sits between operand registers/switches and the board display mux; a start/busy/done handshake lets control logic pace requests.

Parameters:
- WIDTH, 8: operand width in bits; must be ≥ 4 and a multiple of 4 (one lookahead group per nibble).
- DIGITS, 3: number of decimal digits converted and displayed; must satisfy 10^DIGITS > 2^(WIDTH+1)-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A, captured when start is accepted.
- b  in  WIDTH  operand B, captured when start is accepted.
- cin  in  1  carry-in, captured when start is accepted.
- sum  out  WIDTH  registered sum.
- cout  out  1  registered carry-out.
- busy  out  1  high while the conversion runs (CONV state).
- done  out  1  one-cycle pulse; bcd/seg are valid and updated.
- bcd  out  4*DIGITS  BCD of {cout,sum}; digit 0 in bits [3:0].
- seg  out  8*DIGITS  active-low segment codes {a,b,c,d,e,f,g,dp}; digit 0 in bits [7:0].

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, sum=0, cout=0, busy=0, done=0, bcd=0.
  - seg digit0=8'h03 ("0"); all other digits=8'hff (blank).
- Adder:
  - Per nibble: G=a&b, P=a^b; group carries from G/P lookahead; group carry-out ripples between nibbles.
  - Result equals a+b+cin exactly; width is WIDTH+1 with cout as MSB.
- FSM states and transitions:
  - IDLE, start=1: capture a, b, cin; register sum/cout on that edge (E0). Load the shift register with {cout,sum} and clear the BCD accumulator. Go to CONV, iteration counter=0.
  - CONV: one double-dabble iteration per cycle. Each iteration adds 3 to every BCD nibble ≥5, then shifts left by one, MSB of the binary field first. Exactly WIDTH+1 iterations, on edges E1..E(WIDTH+1). The edge that completes iteration WIDTH+1 moves to DONE. start is ignored in CONV.
  - DONE (after edge E(WIDTH+1)): on edge E(WIDTH+2), bcd and seg load from the accumulator. done=1 for the one cycle following E(WIDTH+2), then the FSM returns to IDLE.
  - DONE with start=1 on that edge: the new request is accepted as in IDLE, with no idle cycle. bcd/seg still load with the old result, done still pulses, and the FSM goes to CONV.
- Latency: sum/cout are valid 1 cycle after the accepting edge. done is high during the cycle after E(WIDTH+2), i.e. E(10) when WIDTH=8. Throughput is one result per WIDTH+2 cycles.
- busy: 1 exactly while in CONV; it is 0 in the done cycle.
- Output stability:
  - bcd/seg hold their previous values until the done edge.
  - sum/cout hold until the next accepted start.
  - a, b and cin may change freely after acceptance.
- Segment map (digit value → code): 0:03, 1:9f, 2:25, 3:0d, 4:99, 5:49, 6:41, 7:1f, 8:01, 9:09. BCD nibbles >9 cannot occur; decode them to ff.
- Leading-zero blanking: digits above the most significant non-zero digit show ff. Digit 0 is never blanked. Zeros between non-zero digits are shown as 03.
- Reset mid-conversion: aborts immediately; no done pulse; outputs return to reset values.

Test Plan:
- WIDTH=8, DIGITS=3; rst pulse, then a=0, b=0, cin=0, start 1 cycle → sum=00, cout=0, bcd=000; done at E10 with seg={ff,ff,03}. busy high for exactly 9 cycles.
- a=11, b=4, cin=0 → sum=8'h0f, cout=0, bcd=12'h015, seg={ff,9f,49}.
- a=255, b=255, cin=1 → sum=8'hff, cout=1, bcd=12'h511, seg={49,9f,9f}.
- a=100, b=0, cin=0 → bcd=12'h100, seg={9f,03,03} (interior zeros shown).
- Handshake: start held high continuously with a=1, b=1 → starts are ignored while busy. A new request is accepted on each done edge, so done pulses every 10 cycles with bcd=002. A reset asserted at iteration 4 → no done pulse, and seg/bcd/sum/cout/busy go immediately to their reset values.
- WIDTH=4, DIGITS=2; a=15, b=13, cin=1 → sum=4'hd, cout=1, bcd=8'h29, seg={25,09}; done 6 cycles after the start edge.
